// File: rtl/serial_async_rx.sv
// ---------------------------------------------------------------------------
// serial_async_rx
//   Asynchronous serial receiver (UART-style framing: start, BITS data,
//   optional even parity, STOP_BITS stop). Bits are sampled at mid-bit, timed
//   from the synchronized falling edge of the start bit.
//
//   Optional feature macro: SERIAL_RX_PARITY_EN
//     defined   -> one even-parity bit follows the data bits.
//     undefined -> no parity bit is expected; out_parity_err is tied to 0.
//
//   Ports
//     in_clk             main clock, rising edge
//     in_rst             asynchronous active-low reset
//     in_enable          permits acceptance of a new start bit
//     in_serial          asynchronous serial line, idle high
//     out_ready          high while idle and waiting for a start bit
//     out_word_finished  one-cycle strobe: word and error flags just updated
//     out_parallel       last received word
//     out_frame_err      last word had a low stop bit
//     out_parity_err     last word failed even parity
//
//   State         | meaning
//   ST_READY      | idle, waiting for a falling edge with in_enable high
//   ST_START      | timing to mid start bit, rejects glitches
//   ST_DATA       | sampling BITS data bits
//   ST_PARITY     | sampling the parity bit
//   ST_STOP       | sampling STOP_BITS stop bits, delivers the word
// ---------------------------------------------------------------------------
module serial_async_rx #(
    parameter int MAIN_CLK_HZ   = 50_000_000,
    parameter int SERIAL_CLK_HZ = 9_600,
    parameter int BITS          = 8,
    parameter int STOP_BITS     = 1,
    parameter bit LOWBIT_FIRST  = 1'b1
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_enable,
    input  logic            in_serial,
    output logic            out_ready,
    output logic            out_word_finished,
    output logic [BITS-1:0] out_parallel,
    output logic            out_frame_err,
    output logic            out_parity_err
);

    localparam int DIV    = MAIN_CLK_HZ / SERIAL_CLK_HZ;
    localparam int CNT_W  = $clog2(DIV) + 1;
    localparam int BC_MAX = (BITS > STOP_BITS) ? BITS : STOP_BITS;
    localparam int BC_W   = $clog2(BC_MAX) + 1;

    localparam logic [CNT_W-1:0] HALF_TC   = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC   = CNT_W'(DIV - 1);
    localparam logic [BC_W-1:0]  LAST_DATA = BC_W'(BITS - 1);
    localparam logic [BC_W-1:0]  LAST_STOP = BC_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_READY  = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        sync_q;
    logic              s;
    logic              s_prev;
    logic              start_edge;
    logic              tick;
    logic [CNT_W-1:0]  baud_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [BITS-1:0]   shift_q;
    logic              frame_acc;
`ifdef SERIAL_RX_PARITY_EN
    logic              par_acc;
`endif

    assign s          = sync_q[1];
    assign start_edge = s_prev & ~s & in_enable;

    // First sample lands half a bit after the edge, every later one a full bit on.
    assign tick = (state_q == ST_START) ? (baud_cnt == HALF_TC) : (baud_cnt == FULL_TC);

    // Synchronizer plus one extra flop for falling-edge detection; all idle high.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            sync_q <= 2'b11;
            s_prev <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], in_serial};
            s_prev <= s;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) state_q <= ST_READY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY:  if (start_edge) state_d = ST_START;
            ST_START:  if (tick) state_d = s ? ST_READY : ST_DATA;
            ST_DATA: begin
                if (tick && bit_cnt == LAST_DATA) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick && bit_cnt == LAST_STOP) state_d = ST_READY;
            default:   state_d = ST_READY;
        endcase
    end

    always_comb begin
        out_ready = (state_q == ST_READY);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            baud_cnt          <= '0;
            bit_cnt           <= '0;
            shift_q           <= '0;
            frame_acc         <= 1'b0;
            out_parallel      <= '0;
            out_frame_err     <= 1'b0;
            out_word_finished <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_acc           <= 1'b0;
            out_parity_err    <= 1'b0;
`endif
        end else begin
            out_word_finished <= 1'b0;

            case (state_q)
                ST_START, ST_DATA, ST_PARITY, ST_STOP:
                    baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
                default:
                    baud_cnt <= '0;
            endcase

            case (state_q)
                ST_READY: begin
                    bit_cnt   <= '0;
                    frame_acc <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                    par_acc   <= 1'b0;
`endif
                end
                ST_DATA: begin
                    if (tick) begin
                        if (LOWBIT_FIRST) shift_q <= {s, shift_q[BITS-1:1]};
                        else              shift_q <= {shift_q[BITS-2:0], s};
                        bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                        par_acc <= par_acc ^ s;
`endif
                    end
                end
                ST_PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
                    if (tick) par_acc <= par_acc ^ s;
`endif
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            // Word and flags load together with the strobe.
                            out_parallel      <= shift_q;
                            out_frame_err     <= frame_acc | ~s;
                            out_word_finished <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                            out_parity_err    <= par_acc;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            frame_acc <= frame_acc | ~s;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SERIAL_RX_PARITY_EN
    assign out_parity_err = 1'b0;
`endif

endmodule

// File: doc/serial_async_rx.md
SERIAL_ASYNC_RX -- requirements
Module: serial_async_rx

Interface
REQ-001 SHALL have parameter MAIN_CLK_HZ, default 50_000_000, main clock frequency in Hz.
REQ-002 SHALL have parameter SERIAL_CLK_HZ, default 9_600, baud rate; DIV = MAIN_CLK_HZ/SERIAL_CLK_HZ (integer, >= 4).
REQ-003 SHALL have parameter BITS, default 8, data bits per word.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter LOWBIT_FIRST, default 1'b1; 1 = first received data bit is bit 0, 0 = first is bit BITS-1.
REQ-006 SHALL have port in_clk  input  1  main clock; all logic on rising edge; one clock domain.
REQ-007 SHALL have port in_rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_enable  input  1  permits acceptance of a new start bit.
REQ-009 SHALL have port in_serial  input  1  asynchronous serial line (IC -> FPGA), idle high.
REQ-010 SHALL have port out_ready  output  1  high while in state Ready.
REQ-011 SHALL have port out_word_finished  output  1  one-cycle strobe: out_parallel and error flags updated.
REQ-012 SHALL have port out_parallel  output  BITS  last received word.
REQ-013 SHALL have port out_frame_err  output  1  last word had a low stop bit.
REQ-014 SHALL have port out_parity_err  output  1  last word failed even parity.

Function
REQ-015 in_serial SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value s.
REQ-016 States SHALL be Ready, ReceiveStart, ReceiveData, ReceiveParity, ReceiveStop; internal baud counter (width clog2(DIV)+1) and bit counter.
REQ-017 Ready: on cycle t0 where s falls (previous 1, current 0) and in_enable=1 -> ReceiveStart, baud counter cleared; otherwise stay.
REQ-018 ReceiveStart: sample s at t0+DIV/2; s=0 -> ReceiveData; s=1 -> Ready (glitch rejected, no strobe, outputs unchanged).
REQ-019 ReceiveData: data bit k (k=0..BITS-1, arrival order) sampled at t0+DIV/2+(k+1)*DIV into a shift buffer, placed per LOWBIT_FIRST; after bit BITS-1 -> ReceiveParity (if enabled) else ReceiveStop.
REQ-020 ReceiveParity: one sample DIV cycles after last data sample; -> ReceiveStop.
REQ-021 ReceiveStop: STOP_BITS samples, each DIV cycles apart; any sample 0 sets frame error for this word.
REQ-022 In the cycle after the last stop sample: out_parallel, out_frame_err, out_parity_err SHALL load together, out_word_finished SHALL pulse high exactly one cycle, state -> Ready.
REQ-023 A frame with errors SHALL still be delivered (word plus flags); outputs hold until next strobe.
REQ-024 Return to Ready at mid-stop-bit SHALL allow a start edge in the immediately following bit period to be captured (back-to-back frames, no gap).
REQ-025 in_enable deasserted mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-026 A falling edge on s outside Ready SHALL be ignored except as sampled data.
REQ-027 Illegal state encodings SHALL go to Ready next cycle.

Reset
REQ-028 While in_rst=0: state Ready, counters 0, synchronizer flops 1, out_parallel 0, out_word_finished 0, out_frame_err 0, out_parity_err 0, out_ready 1.
REQ-029 Reset asserted mid-frame SHALL discard the partial word with no strobe; after release, reception starts only on a new falling edge.

Configuration
REQ-030 Macro SERIAL_RX_PARITY_EN defined: frame contains one even-parity bit after data; out_parity_err = XOR(data bits, parity bit) at delivery.
REQ-031 Macro SERIAL_RX_PARITY_EN undefined: no ReceiveParity state reachable, no parity bit expected, out_parity_err constant 0.

Verification (MAIN_CLK_HZ=1_000_000, SERIAL_CLK_HZ=100_000, DIV=10, BITS=8, STOP_BITS=1)
REQ-032 Send 0xA5 LSB-first, stop=1, parity off -> single strobe, out_parallel=0xA5, out_frame_err=0, out_ready back to 1.
REQ-033 Low pulse of 3 cycles on idle line -> no strobe, returns to Ready, out_parallel unchanged.
REQ-034 Send 0x3C with stop bit 0 -> strobe, out_parallel=0x3C, out_frame_err=1; next good frame 0x01 clears flag to 0.
REQ-035 With SERIAL_RX_PARITY_EN: 0x07 with parity 1 -> out_parity_err=0; parity 0 -> out_parity_err=1.
REQ-036 Back-to-back 0x55 then 0xAA, no idle gap -> two strobes with correct words; LOWBIT_FIRST=0 with 0x80 line pattern yields 0x01.
REQ-037 Reset pulse after 4th data bit of 0xFF -> no strobe, out_parallel=0; following frame 0x12 received correctly.
